// File: rtl/counter_seq_ctrl.sv
// Multi-pass run counter: counts 0..limit for (reps+1) passes per accepted command,
// with pause (HOLD), abort, per-pass wrap pulse and a completion pulse.
module counter_seq_ctrl #(
  parameter int DATA_W = 4,
  parameter int PASS_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_limit,
  input  logic [PASS_W-1:0] cmd_reps,
  input  logic              pause,
  input  logic              abort,
  output logic [DATA_W-1:0] count,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HOLD   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_count;
  logic [DATA_W-1:0]   w_count_nxt;
  logic [PASS_W-1:0]   r_pass;
  logic [PASS_W-1:0]   w_pass_nxt;
  logic [DATA_W-1:0]   r_limit;
  logic [DATA_W-1:0]   w_limit_nxt;
  logic [PASS_W-1:0]   r_reps;
  logic [PASS_W-1:0]   w_reps_nxt;
  logic                r_wrap;
  logic                w_wrap_nxt;
  logic                r_done;
  logic                w_done_nxt;

  // Priority inside RUN/HOLD: abort beats pause beats counting.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pass_nxt  = r_pass;
    w_limit_nxt = r_limit;
    w_reps_nxt  = r_reps;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        w_pass_nxt  = '0;
        if (cmd_valid) begin
          w_limit_nxt = cmd_limit;
          w_reps_nxt  = cmd_reps;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          w_pass_nxt  = '0;
        end else if (pause) begin
          w_state_nxt = S_HOLD;
        end else if (r_count == r_limit) begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
          if (r_pass == r_reps) begin
            w_state_nxt = S_FINISH;
            w_done_nxt  = 1'b1;
          end else begin
            w_pass_nxt = r_pass + 1'b1;
          end
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      S_HOLD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          w_pass_nxt  = '0;
        end else if (!pause) begin
          w_state_nxt = S_RUN;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_pass_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_pass_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_pass  <= '0;
      r_limit <= '0;
      r_reps  <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pass  <= w_pass_nxt;
      r_limit <= w_limit_nxt;
      r_reps  <= w_reps_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign count     = r_count;
  assign pass_idx  = r_pass;
  assign wrap      = r_wrap;
  assign done      = r_done;

endmodule
